// File: rtl/click_pkg.sv
// ---------------------------------------------------------------------------
// click_pkg
// Shared definitions for the click decoder slice: FSM state encodings and
// the click-counter width.
//
// Optional build macro (used by click_decoder): CLICK_DECODER_HOLDOFF_EN
// ---------------------------------------------------------------------------
package click_pkg;

  // Width of the per-group press counter (holds 0..3).
  localparam int CLICK_W = 2;

  // HOLDOFF is only entered when CLICK_DECODER_HOLDOFF_EN is defined; in the
  // default build the encoding is unreachable and decodes back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GAP     = 2'b01,
    ST_EMIT    = 2'b10,
    ST_HOLDOFF = 2'b11
  } state_e;

endpackage : click_pkg

// File: rtl/click_gap_timer.sv
// ---------------------------------------------------------------------------
// click_gap_timer
// Saturating idle-gap counter. Counts up while en is high and parks at
// GAP_CNT-1 so it never wraps; done flags that terminal value.
//
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset (count -> 0)
//   clear in   restart the count at 0 (wins over en)
//   en    in   advance the count by one
//   done  out  count == GAP_CNT-1
// ---------------------------------------------------------------------------
module click_gap_timer
  import click_pkg::*;
#(
  parameter int GAP_CNT = 30_000_000,
  parameter int GAP_W   = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic done
);

  localparam logic [GAP_W-1:0] LAST = GAP_W'(GAP_CNT - 1);

  logic [GAP_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en && !done) begin
      count_q <= count_q + GAP_W'(1);
    end
  end

  assign done = (count_q == LAST);

endmodule : click_gap_timer

// File: rtl/click_decoder.sv
// ---------------------------------------------------------------------------
// click_decoder
// Groups debounced press pulses into single/double/triple click events.
// A group stays open while presses keep arriving within GAP_CNT idle cycles;
// the third press closes it immediately. Each event is a one-cycle pulse
// decoded from the FSM state (no output registers).
//
// Ports:
//   clk           in   system clock (100 MHz)
//   rst           in   synchronous active-high reset
//   tick          in   one-cycle debounced press pulse
//   single_click  out  pulse: group of 1 press
//   double_click  out  pulse: group of 2 presses
//   triple_click  out  pulse: group of 3 presses
//   busy          out  high while a group is open (GAP/EMIT[/HOLDOFF])
//
// Build macro: CLICK_DECODER_HOLDOFF_EN -- when defined, every event is
// followed by a GAP_CNT-cycle HOLDOFF during which presses are ignored.
// ---------------------------------------------------------------------------
module click_decoder
  import click_pkg::*;
#(
  parameter int GAP_CNT    = 30_000_000,
  parameter int GAP_W      = 25,
  parameter int MAX_CLICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic single_click,
  output logic double_click,
  output logic triple_click,
  output logic busy
);

  localparam logic [CLICK_W-1:0] MAX_C = CLICK_W'(MAX_CLICKS);

  state_e               state_q, state_d;
  logic [CLICK_W-1:0]   clicks_q, clicks_d;
  logic                 tmr_clear, tmr_en, tmr_done;
  logic                 emit_ok;

  click_gap_timer #(
    .GAP_CNT (GAP_CNT),
    .GAP_W   (GAP_W)
  ) u_gap_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .en    (tmr_en),
    .done  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      clicks_q <= '0;
    end else begin
      state_q  <= state_d;
      clicks_q <= clicks_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clicks_d  = clicks_q;
    tmr_clear = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          clicks_d  = CLICK_W'(1);
          tmr_clear = 1'b1;
          state_d   = ST_GAP;
        end
      end
      ST_GAP: begin
        // A press in the timeout-decision cycle still belongs to the group.
        if (tick) begin
          if (clicks_q + CLICK_W'(1) == MAX_C) begin
            clicks_d = MAX_C;
            state_d  = ST_EMIT;
          end else begin
            clicks_d  = clicks_q + CLICK_W'(1);
            tmr_clear = 1'b1;
          end
        end else if (tmr_done) begin
          state_d = ST_EMIT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_EMIT: begin
`ifdef CLICK_DECODER_HOLDOFF_EN
        // Restart the timer so HOLDOFF lasts exactly GAP_CNT cycles.
        clicks_d  = '0;
        tmr_clear = 1'b1;
        state_d   = ST_HOLDOFF;
`else
        // A press landing on the emit cycle opens the next group directly.
        if (tick) begin
          clicks_d  = CLICK_W'(1);
          tmr_clear = 1'b1;
          state_d   = ST_GAP;
        end else begin
          clicks_d = '0;
          state_d  = ST_IDLE;
        end
`endif
      end
`ifdef CLICK_DECODER_HOLDOFF_EN
      ST_HOLDOFF: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
`endif
      default: begin
        state_d  = ST_IDLE;
        clicks_d = '0;
      end
    endcase
  end

  // Outputs are masked by rst so a group caught in EMIT by a reset is
  // discarded without a pulse.
  assign emit_ok      = (state_q == ST_EMIT) && !rst;
  assign single_click = emit_ok && (clicks_q == CLICK_W'(1));
  assign double_click = emit_ok && (clicks_q == CLICK_W'(2));
  assign triple_click = emit_ok && (clicks_q == CLICK_W'(3));
  assign busy         = (state_q != ST_IDLE) && !rst;

endmodule : click_decoder
